// File: rtl/uart_tx_buffer.sv
// Buffered 8N1 UART transmitter: sends a p_data_buffer-byte word MSB byte first.
// Define UART_TX_STOP2_EN for two stop bits per frame.
module uart_tx_buffer #(
    parameter int p_preescaler  = 8,
    parameter int p_data_buffer = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [8*p_data_buffer-1:0] ip_data,
    input  logic                       i_dv,
    output logic                       o_tx,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int W  = 8 * p_data_buffer;
    localparam int PW = $clog2(p_preescaler);
    localparam int BW = $clog2(p_data_buffer + 1);
    localparam logic [PW-1:0] TICK_AT   = PW'(p_preescaler - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(p_data_buffer - 1);
`ifdef UART_TX_STOP2_EN
    localparam logic [2:0] STOP_LAST = 3'd1;
`else
    localparam logic [2:0] STOP_LAST = 3'd0;
`endif

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    buf_q, buf_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [2:0]      bit_q, bit_d;
    logic [BW-1:0]   byte_q, byte_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tick;
    logic            accept;
    logic [7:0]      cur_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            presc_q <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            presc_q <= presc_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tick   = (presc_q == TICK_AT);
    assign accept = i_dv && !busy_q;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        presc_d = '0;
        bit_d   = bit_q;
        byte_d  = byte_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                byte_d  = '0;
                bit_d   = '0;
                if (accept) begin
                    state_d = START;
                    buf_d   = ip_data;
                end
            end
            START: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        bit_d   = '0;
                    end
                end
            end
            STOP: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        if (byte_q == LAST_BYTE) begin
                            state_d = DONE;
                        end else begin
                            // next byte moves into the top slot, no idle gap
                            state_d = START;
                            byte_d  = byte_q + BW'(1);
                            buf_d   = buf_q << 8;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so the line changes on the edge
    assign cur_byte = buf_d[W-1 -: 8];

    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b0;
        unique case (state_d)
            START: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
            end
            DATA: begin
                tx_d   = cur_byte[bit_d];
                busy_d = 1'b1;
            end
            STOP:    busy_d = 1'b1;
            DONE:    done_d = 1'b1;
            default: tx_d   = 1'b1;
        endcase
    end

    assign o_tx   = tx_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: three parameterisations checked cycle by cycle
// against a frame-level model of the serial line.
module tb_uart_tx_buffer;

`ifdef UART_TX_STOP2_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    int PP[3] = '{8, 4, 8};
    int BB[3] = '{1, 2, 16};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   dv = '0;
    logic [127:0] dat [3];
    logic [2:0]   tx_w, busy_w, done_w;
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    uart_tx_buffer #(.p_preescaler(8), .p_data_buffer(1)) u_a (
        .clk(clk), .rst(rst), .ip_data(dat[0][7:0]), .i_dv(dv[0]),
        .o_tx(tx_w[0]), .o_busy(busy_w[0]), .o_done(done_w[0]));

    uart_tx_buffer #(.p_preescaler(4), .p_data_buffer(2)) u_b (
        .clk(clk), .rst(rst), .ip_data(dat[1][15:0]), .i_dv(dv[1]),
        .o_tx(tx_w[1]), .o_busy(busy_w[1]), .o_done(done_w[1]));

    uart_tx_buffer #(.p_preescaler(8), .p_data_buffer(16)) u_c (
        .clk(clk), .rst(rst), .ip_data(dat[2]), .i_dv(dv[2]),
        .o_tx(tx_w[2]), .o_busy(busy_w[2]), .o_done(done_w[2]));

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Line level of bit j of a transfer of word w with b bytes
    function automatic logic ebit(input int b, input logic [127:0] w,
                                  input int j);
        int f;
        int pos;
        logic [7:0] by;
        f   = j / FB;
        pos = j % FB;
        by  = w[8*(b-f)-1 -: 8];
        if (pos == 0) return 1'b0;
        if (pos <= 8) return by[pos-1];
        return 1'b1;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Request must already be driven on dv[d]; the next edge is accept edge N.
    // mode 0: plain, 1: extra request at N+20, 2: reset at N+30.
    // chain: issue the next request during the DONE cycle.
    task automatic track(input int d, input logic [127:0] w, input int mode,
                         input bit chain, input logic [127:0] nxt);
        int p;
        int b;
        int len;
        p   = PP[d];
        b   = BB[d];
        len = FB * b * p;
        for (int k = 0; k < len; k++) begin
            @(posedge clk);
            @(negedge clk);
            dv[d] = 1'b0;
            if (k == 1) dat[d] = rnd128();
            chk($sformatf("tx d%0d k%0d", d, k), 128'(tx_w[d]), 128'(ebit(b, w, k / p)));
            chk($sformatf("busy d%0d k%0d", d, k), 128'(busy_w[d]), 128'(1));
            chk($sformatf("done d%0d k%0d", d, k), 128'(done_w[d]), 128'(0));
            if (mode == 1 && k == 20) begin
                dat[d] = '1;
                dv[d]  = 1'b1;
            end
            if (mode == 2 && k == 30) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                chk("rst tx", 128'(tx_w[d]), 128'(1));
                chk("rst busy", 128'(busy_w[d]), 128'(0));
                for (int m = 0; m < 3 * p; m++) begin
                    chk("rst no done", 128'(done_w[d]), 128'(0));
                    @(negedge clk);
                end
                return;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("end done d%0d", d), 128'(done_w[d]), 128'(1));
        chk($sformatf("end busy d%0d", d), 128'(busy_w[d]), 128'(0));
        chk($sformatf("end tx d%0d", d), 128'(tx_w[d]), 128'(1));
        if (chain) begin
            dat[d] = nxt;
            dv[d]  = 1'b1;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("done drop d%0d", d), 128'(done_w[d]), 128'(0));
        chk($sformatf("idle tx d%0d", d), 128'(tx_w[d]), 128'(1));
    endtask

    task automatic req(input int d, input logic [127:0] w);
        dat[d] = w;
        dv[d]  = 1'b1;
    endtask

    initial begin
        logic [127:0] w1;
        logic [127:0] w2;
        for (int i = 0; i < 3; i++) dat[i] = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset tx d%0d", i), 128'(tx_w[i]), 128'(1));
            chk($sformatf("reset busy d%0d", i), 128'(busy_w[i]), 128'(0));
            chk($sformatf("reset done d%0d", i), 128'(done_w[i]), 128'(0));
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        req(0, 128'hA5);
        track(0, 128'hA5, 0, 1'b0, '0);

        req(1, 128'h1234);
        track(1, 128'h1234, 0, 1'b0, '0);

        req(0, 128'h3C);
        track(0, 128'h3C, 1, 1'b0, '0);

        w1 = 128'($urandom_range(0, 255));
        req(0, w1);
        track(0, w1, 2, 1'b0, '0);
        req(0, 128'h5A);
        track(0, 128'h5A, 0, 1'b0, '0);

        w1 = rnd128();
        w2 = rnd128();
        req(2, w1);
        track(2, w1, 0, 1'b1, w2);
        track(2, w2, 0, 1'b0, '0);

        req(1, 128'hC3E1);
        track(1, 128'hC3E1, 0, 1'b0, '0);

        w1 = 128'($urandom_range(0, 65535));
        req(1, w1);
        for (int r = 0; r < 3; r++) begin
            w2 = 128'($urandom_range(0, 65535));
            track(1, w1, 0, 1'b1, w2);
            w1 = w2;
        end
        track(1, w1, 0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Buffered UART transmitter: captures a `p_data_buffer`-byte word on a single-cycle request and serialises it on `o_tx` as back-to-back 8N1 frames. Each frame is LSB first, bytes sent from the most-significant byte down. It is the transmit-side peer of the team's buffered UART receiver. With equal `p_preescaler` and `p_data_buffer`, the receiver reconstructs the identical word. It sits between a local controller that produces packet words and the serial line.

## Interface
- `p_preescaler`, 8, clk cycles per serial bit; legal range ≥ 2.
- `p_data_buffer`, 16, bytes per transfer; legal range ≥ 1.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ip_data`  in  8·`p_data_buffer`  word to send; sampled only when a request is accepted.
- `i_dv`  in  1  send request; single-cycle or level.
- `o_tx`  out  1  serial line, registered; idle high.
- `o_busy`  out  1  transfer in progress; `i_dv` is ignored while high.
- `o_done`  out  1  one-cycle pulse after the final stop bit.

## Operation
- **Reset values:** `o_tx`=1, `o_busy`=0, `o_done`=0, state IDLE. Bit counter, byte counter and prescaler counter are all 0.
- **Accept:** a request is accepted when `i_dv`=1 and `o_busy`=0, sampled at a clk edge.
  - On accept, `ip_data` is copied into an internal shift buffer and the prescaler counter is cleared.
  - Later changes on `ip_data` have no effect on the transfer.
- **Prescaler:** the counter is `$clog2(p_preescaler)` bits wide, counts 0..`p_preescaler`-1 and wraps.
  - A tick is produced at count `p_preescaler`-1.
  - The prescaler runs only while `o_busy`=1.
- **States:** IDLE → START → DATA → STOP → (START | DONE) → IDLE.
  - **IDLE:** `o_tx`=1. On accept, go to START.
  - **START:** `o_tx`=0 for one bit period, then go to DATA.
  - **DATA:** `o_tx` = current byte bit n, n = 0..7, LSB first. Each bit lasts one bit period. After bit 7, go to STOP.
  - **STOP:** `o_tx`=1 for one bit period. Then:
    - if bytes remain, go to START with no idle gap;
    - otherwise go to DONE.
  - **DONE:** lasts one cycle. `o_done`=1 and `o_busy`=0, then return to IDLE.
- **Byte order:** byte k (k = 0..`p_data_buffer`-1) is `ip_data[8·(p_data_buffer-k)-1 -: 8]`, i.e. the most-significant byte goes first.
  - The byte counter is `$clog2(p_data_buffer+1)` bits wide and counts up from 0.
  - The last byte is detected at count `p_data_buffer`-1; the counter does not wrap.
- **Request in DONE:** `i_dv` seen in the DONE cycle is accepted, because `o_busy`=0 there. The next start bit then begins on the following edge, with no idle bit between transfers.
- **Request while busy:** `i_dv` while `o_busy`=1 is dropped. There is no queuing and no error flag.
- **Reset mid-transfer:** on the next edge `o_tx` returns to 1, `o_busy` to 0, and no `o_done` is emitted. The partial frame is abandoned.

## Timing
- Let B = `p_data_buffer`, p = `p_preescaler`, and let accept occur at edge N.
- `o_busy`=1 from edge N.
- Bit j of the whole transfer (j = 0..10B-1) drives `o_tx` from edge N+j·p until edge N+(j+1)·p.
  - Every bit lasts exactly p cycles, with no jitter.
- At edge N+10·B·p: `o_done`=1, `o_busy`=0, `o_tx`=1. At edge N+10·B·p+1: `o_done`=0.
- Latency from accept to start bit on the line is 0 cycles, because `o_tx` is registered at the accept edge.

## Configuration
- **`UART_TX_STOP2_EN` defined:** STOP lasts two bit periods.
  - Each frame is 11 bits and a transfer is 11·B·p cycles.
  - `o_done` is at edge N+11·B·p.
  - The receiver remains compatible because extra idle-high time is tolerated.
- **Undefined (default):** one stop bit, timing exactly as in Timing.

## Test plan
- **Single byte** (B=1, p=8, `ip_data`=8'hA5, `i_dv` pulse at edge N):
  - `o_tx` reads 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles.
  - `o_done` at N+80; `o_busy` high for cycles N..N+79.
- **Byte order and no gap** (B=2, p=4, `ip_data`=16'h1234):
  - First frame carries 8'h12, second carries 8'h34.
  - The second start bit begins at N+40; `o_done` at N+80.
- **Request while busy:**
  - B=1, p=8, 8'h3C accepted.
  - `i_dv` with 8'hFF at N+20 is ignored; the line still carries 8'h3C.
  - `o_done` fires once, at N+80.
- **Reset mid-frame:**
  - Assert `rst` at N+30 (B=1, p=8).
  - Next edge: `o_tx`=1, `o_busy`=0; `o_done` never pulses.
  - A new request for 8'h5A afterwards transmits correctly.
- **Loopback** (B=16, p=8, random 128-bit word, `o_tx` wired to the receiver's input):
  - The receiver outputs the identical word with its valid asserted.
  - A back-to-back second request issued in the DONE cycle is also received correctly.
- **`UART_TX_STOP2_EN` build** (B=2, p=4, 16'hC3E1):
  - Stop bits are 8 cycles high.
  - The second start bit begins at N+44; `o_done` at N+88.
